// File: rtl/tmr_mon_pkg.sv
// Shared types for the TMR error monitor: FSM states and disagreement classes.
package tmr_mon_pkg;

  localparam int NHARTS_TMR = 3;

  typedef enum logic [2:0] {
    MON_IDLE,
    MON_WATCH,
    MON_PENDING,
    MON_FAULT,
    MON_FATAL
  } tmr_mon_state_e;

  typedef enum logic [1:0] {
    CLS_OK,
    CLS_SINGLE,
    CLS_TRIPLE
  } tmr_mon_class_e;

endpackage

// File: rtl/tmr_vote_classifier.sv
// Combinational 2-of-3 voter and disagreement classifier over three hart signatures.
module tmr_vote_classifier
  import tmr_mon_pkg::*;
#(
  parameter int SW = 66
) (
  input  logic [SW-1:0]  sig0,
  input  logic [SW-1:0]  sig1,
  input  logic [SW-1:0]  sig2,
  output logic [SW-1:0]  maj_sig,
  output tmr_mon_class_e cls,
  output logic [1:0]     fault_id
);

  logic m01, m02, m12;

  assign m01 = (sig0 != sig1);
  assign m02 = (sig0 != sig2);
  assign m12 = (sig1 != sig2);

  assign maj_sig = (sig0 & sig1) | (sig0 & sig2) | (sig1 & sig2);

  // Equality is transitive, so a lone mismatch flag is unreachable.
  always_comb begin
    cls      = CLS_OK;
    fault_id = 2'd0;
    if (m01 && m02 && m12) begin
      cls = CLS_TRIPLE;
    end else if (m01 && m02) begin
      cls      = CLS_SINGLE;
      fault_id = 2'd0;
    end else if (m01 && m12) begin
      cls      = CLS_SINGLE;
      fault_id = 2'd1;
    end else if (m02 && m12) begin
      cls      = CLS_SINGLE;
      fault_id = 2'd2;
    end
  end

endmodule

// File: rtl/tmr_error_monitor.sv
// Majority voter for the three lockstep harts' data-bus requests, with persistence-filtered
// fault classification feeding the TMR recovery FSMs.
//
//   state       | meaning
//   MON_IDLE    | voter disabled, nothing classified
//   MON_WATCH   | lockstep healthy, watching for disagreement
//   MON_PENDING | single-hart mismatch seen, counting persistence
//   MON_FAULT   | single-hart fault latched until clear_i
//   MON_FATAL   | uncorrectable disagreement latched until clear_i
module tmr_error_monitor
  import tmr_mon_pkg::*;
#(
  parameter int NHARTS  = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int PERSIST = 2,
  parameter int CNT_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [NHARTS-1:0]            core_req_i,
  input  logic [NHARTS-1:0]            core_we_i,
  input  logic [NHARTS-1:0][AW-1:0]    core_addr_i,
  input  logic [NHARTS-1:0][DW-1:0]    core_wdata_i,
  output logic                         voted_req_o,
  output logic                         voted_we_o,
  output logic [AW-1:0]                voted_addr_o,
  output logic [DW-1:0]                voted_wdata_o,
  output logic                         tmr_error_o,
  output logic [NHARTS-1:0]            voter_id_error_o,
  output logic                         fatal_error_o,
  output logic [CNT_W-1:0]             error_count_o
);

  localparam int SW = 2 + AW + DW;

  if (NHARTS != NHARTS_TMR) begin : g_nharts_chk
    $error("tmr_error_monitor: NHARTS must be 3");
  end
  if (PERSIST < 1 || PERSIST > 15) begin : g_persist_chk
    $error("tmr_error_monitor: PERSIST must be in 1..15");
  end

  logic [NHARTS_TMR-1:0][SW-1:0] sig;
  logic [SW-1:0]                 maj_sig;
  tmr_mon_class_e                cls;
  logic [1:0]                    fault_id;

  // Idle harts compare equal regardless of stale we/addr/wdata.
  always_comb begin
    for (int h = 0; h < NHARTS_TMR; h++) begin
      sig[h] = core_req_i[h] ? {1'b1, core_we_i[h], core_addr_i[h], core_wdata_i[h]} : '0;
    end
  end

  tmr_vote_classifier #(.SW(SW)) u_classifier (
    .sig0     (sig[0]),
    .sig1     (sig[1]),
    .sig2     (sig[2]),
    .maj_sig  (maj_sig),
    .cls      (cls),
    .fault_id (fault_id)
  );

  assign {voted_req_o, voted_we_o, voted_addr_o, voted_wdata_o} = maj_sig;

  tmr_mon_state_e state_q, state_d;
  logic [1:0]     cand_q, cand_d;
  logic [3:0]     pcnt_q, pcnt_d;
  logic [3:0]     pcnt_inc;
  logic           enter_err;

  assign pcnt_inc = pcnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    pcnt_d  = pcnt_q;
    if (clear_i) begin
      state_d = MON_IDLE;
      cand_d  = 2'd0;
      pcnt_d  = 4'd0;
    end else if (!enable_i && (state_q == MON_WATCH || state_q == MON_PENDING)) begin
      state_d = MON_IDLE;
      cand_d  = 2'd0;
      pcnt_d  = 4'd0;
    end else begin
      unique case (state_q)
        MON_IDLE: begin
          if (enable_i) state_d = MON_WATCH;
        end
        MON_WATCH: begin
          if (cls == CLS_SINGLE) begin
            cand_d  = fault_id;
            pcnt_d  = 4'd1;
            state_d = (PERSIST == 1) ? MON_FAULT : MON_PENDING;
          end else if (cls == CLS_TRIPLE) begin
            state_d = MON_FATAL;
          end
        end
        MON_PENDING: begin
          if (cls == CLS_OK) begin
            state_d = MON_WATCH;
            pcnt_d  = 4'd0;
          end else if (cls == CLS_SINGLE && fault_id == cand_q) begin
            pcnt_d = pcnt_inc;
            if (pcnt_inc == 4'(PERSIST)) state_d = MON_FAULT;
          end else begin
            state_d = MON_FATAL;
          end
        end
        MON_FAULT, MON_FATAL: ;
        default: state_d = MON_IDLE;
      endcase
    end
  end

  assign enter_err = (state_d == MON_FAULT || state_d == MON_FATAL) &&
                     (state_q != MON_FAULT && state_q != MON_FATAL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= MON_IDLE;
      cand_q           <= 2'd0;
      pcnt_q           <= 4'd0;
      tmr_error_o      <= 1'b0;
      voter_id_error_o <= '0;
      fatal_error_o    <= 1'b0;
      error_count_o    <= '0;
    end else begin
      state_q          <= state_d;
      cand_q           <= cand_d;
      pcnt_q           <= pcnt_d;
      tmr_error_o      <= (state_d == MON_FAULT);
      voter_id_error_o <= (state_d == MON_FAULT) ? ({{(NHARTS-1){1'b0}}, 1'b1} << cand_d) : '0;
      fatal_error_o    <= (state_d == MON_FATAL);
      if (enter_err && error_count_o != '1) error_count_o <= error_count_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tmr_error_monitor.sv
// Bench for tmr_error_monitor: directed plan scenarios then randomized traffic vs. a behavioural model.
module tb_tmr_error_monitor;

  localparam int PERSIST = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             enable_i = 1'b0;
  logic             clear_i = 1'b0;
  logic [2:0]       req = '0;
  logic [2:0]       we = '0;
  logic [2:0][31:0] addr = '0;
  logic [2:0][31:0] wdata = '0;
  logic             voted_req_o, voted_we_o;
  logic [31:0]      voted_addr_o, voted_wdata_o;
  logic             tmr_error_o, fatal_error_o;
  logic [2:0]       voter_id_error_o;
  logic [7:0]       error_count_o;

  tmr_error_monitor #(.NHARTS(3), .AW(32), .DW(32), .PERSIST(PERSIST), .CNT_W(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .enable_i         (enable_i),
    .clear_i          (clear_i),
    .core_req_i       (req),
    .core_we_i        (we),
    .core_addr_i      (addr),
    .core_wdata_i     (wdata),
    .voted_req_o      (voted_req_o),
    .voted_we_o       (voted_we_o),
    .voted_addr_o     (voted_addr_o),
    .voted_wdata_o    (voted_wdata_o),
    .tmr_error_o      (tmr_error_o),
    .voter_id_error_o (voter_id_error_o),
    .fatal_error_o    (fatal_error_o),
    .error_count_o    (error_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Model: monitor armed?, latched outcome (0 none, 1 fault, 2 fatal), run of same-hart mismatches.
  int m_active, m_latched, m_streak, m_sid, m_fid, m_cnt;

  function automatic void model_reset();
    m_active = 0; m_latched = 0; m_streak = 0; m_sid = 0; m_fid = 0; m_cnt = 0;
  endfunction

  function automatic logic [65:0] sig(int h);
    return req[h] ? {1'b1, we[h], addr[h], wdata[h]} : 66'd0;
  endfunction

  function automatic void model_latch(int kind, int id);
    m_latched = kind;
    m_fid     = id;
    m_active  = 0;
    m_streak  = 0;
    if (m_cnt < 255) m_cnt++;
  endfunction

  function automatic void model_step();
    logic [65:0] s0, s1, s2;
    int nd, odd;
    s0 = sig(0); s1 = sig(1); s2 = sig(2);
    odd = 0;
    if (s0 == s1 && s1 == s2) nd = 1;
    else if (s0 != s1 && s0 != s2 && s1 != s2) nd = 3;
    else begin
      nd = 2;
      odd = (s1 == s2) ? 0 : (s0 == s2) ? 1 : 2;
    end
    if (clear_i) begin
      m_latched = 0; m_active = 0; m_streak = 0;
    end else if (m_latched != 0) begin
    end else if (m_active == 0) begin
      if (enable_i) m_active = 1;
    end else if (!enable_i) begin
      m_active = 0; m_streak = 0;
    end else if (nd == 3) begin
      model_latch(2, 0);
    end else if (nd == 2) begin
      if (m_streak > 0 && odd != m_sid) model_latch(2, 0);
      else begin
        m_streak++;
        m_sid = odd;
        if (m_streak >= PERSIST) model_latch(1, odd);
      end
    end else begin
      m_streak = 0;
    end
  endfunction

  function automatic logic [31:0] maj32(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1;
    if (&req) begin
      check("voted_req", voted_req_o, 1'b1);
      check("voted_we", voted_we_o, (int'(we[0]) + int'(we[1]) + int'(we[2])) >= 2);
      check("voted_addr", voted_addr_o, maj32(addr[0], addr[1], addr[2]));
      check("voted_wdata", voted_wdata_o, maj32(wdata[0], wdata[1], wdata[2]));
    end
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check("tmr_error", tmr_error_o, m_latched == 1);
    check("voter_id", voter_id_error_o, (m_latched == 1) ? (3'b001 << m_fid) : 3'b000);
    check("fatal_error", fatal_error_o, m_latched == 2);
    check("error_count", error_count_o, m_cnt);
  endtask

  task automatic lockstep();
    req = 3'b111; we = 3'b000;
    for (int h = 0; h < 3; h++) begin
      addr[h] = 32'h1000_0040; wdata[h] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  initial begin
    int flt_left, flt_h;
    model_reset();
    #12;
    check("rst_tmr_error", tmr_error_o, 1'b0);
    check("rst_voter_id", voter_id_error_o, 3'b000);
    check("rst_fatal", fatal_error_o, 1'b0);
    check("rst_count", error_count_o, 8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Normal lockstep
    enable_i = 1'b1; lockstep();
    for (int i = 0; i < 100; i++) tick();
    check("lock_addr", voted_addr_o, 32'h1000_0040);
    check("lock_wdata", voted_wdata_o, 32'hDEAD_BEEF);

    // Transient on hart1 is filtered, then a 2-cycle fault on hart2 latches
    wdata[1] = 32'hDEAD_BEEE; tick(); lockstep();
    check("transient_wdata", voted_wdata_o, 32'hDEAD_BEEF);
    tick(); tick();
    check("transient_flag", tmr_error_o, 1'b0);
    check("transient_count", error_count_o, 8'd0);
    addr[2] = 32'h2000_0000; tick();
    check("pending_no_flag", tmr_error_o, 1'b0);
    tick(); lockstep();
    check("fault_flag", tmr_error_o, 1'b1);
    check("fault_id", voter_id_error_o, 3'b100);
    check("fault_count", error_count_o, 8'd1);
    tick(); tick();

    // Clear releases the fault; next cycle re-arms
    do_clear();
    check("clear_flag", tmr_error_o, 1'b0);
    check("clear_id", voter_id_error_o, 3'b000);
    tick();

    // Triple disagreement
    wdata[0] = 32'h1; wdata[1] = 32'h2; wdata[2] = 32'h4; tick(); lockstep();
    check("triple_fatal", fatal_error_o, 1'b1);
    check("triple_tmr", tmr_error_o, 1'b0);
    check("triple_count", error_count_o, 8'd2);
    do_clear(); tick();

    // Masking: idle harts with differing payloads are not an error
    req = 3'b000; addr[0] = 32'h1234_5678; wdata[0] = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) tick();
    check("mask_count", error_count_o, 8'd2);
    lockstep(); tick();

    // Abort: PENDING then enable dropped
    wdata[1] = 32'h0; tick(); lockstep();
    enable_i = 1'b0; wdata[1] = 32'h0; tick();
    check("abort_flag", tmr_error_o | fatal_error_o, 1'b0);
    lockstep(); enable_i = 1'b1; tick(); tick();

    // PENDING with faulty id switching to hart0
    wdata[1] = 32'h0; tick(); lockstep();
    wdata[0] = 32'h0; tick(); lockstep();
    check("switch_fatal", fatal_error_o, 1'b1);
    do_clear(); tick();

    // Async reset while a fault is latched
    addr[2] = 32'h0; tick(); tick(); lockstep();
    check("pre_rst_fault", tmr_error_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_tmr", tmr_error_o, 1'b0);
    check("async_rst_id", voter_id_error_o, 3'b000);
    check("async_rst_count", error_count_o, 8'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Randomized traffic
    flt_left = 0; flt_h = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ba, bd;
      logic bw;
      ba = $urandom(); bd = $urandom(); bw = 1'($urandom_range(1, 0));
      req = ($urandom_range(99, 0) < 90) ? 3'b111 : 3'b000;
      for (int h = 0; h < 3; h++) begin
        we[h] = bw; addr[h] = ba; wdata[h] = bd;
      end
      if (flt_left == 0 && $urandom_range(99, 0) < 8) begin
        flt_left = $urandom_range(3, 1);
        flt_h    = $urandom_range(2, 0);
      end
      if (flt_left > 0) begin
        if ($urandom_range(99, 0) < 3) flt_h = (flt_h + 1) % 3;
        if ($urandom_range(1, 0) == 1) addr[flt_h] = addr[flt_h] ^ ($urandom() | 32'h1);
        else wdata[flt_h] = wdata[flt_h] ^ ($urandom() | 32'h1);
        flt_left--;
      end else if ($urandom_range(99, 0) < 1) begin
        wdata[0] = wdata[0] ^ 32'h1;
        wdata[1] = wdata[1] ^ 32'h2;
      end
      enable_i = ($urandom_range(99, 0) < 97);
      clear_i  = ($urandom_range(99, 0) < 5);
      tick();
    end
    clear_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tmr_error_monitor.md
Name: tmr_error_monitor

Overview:
- Sits directly upstream of the safe-mode controller's TMR recovery FSMs.
- Majority-votes the three harts' data-bus requests onto a single bus while lockstep TMR is active.
- Classifies disagreements and filters out transients with a persistence counter.
- Latches a persistent fault as tmr_error_o plus a one-hot faulty-hart mask on voter_id_error_o. The recovery FSMs consume these: healthy harts go to DMR, the faulty hart goes to reset.

Parameters:
- NHARTS, 3, number of harts; fixed at 3. Any other value is an elaboration error.
- AW, 32, address width.
- DW, 32, write-data width.
- PERSIST, 2, consecutive mismatching cycles before a fault latches; legal range 1..15.
- CNT_W, 8, width of the error counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  voter enable, driven by Tmr_voter_enable_o.
- clear_i  in  1  single-cycle pulse; releases a latched FAULT or FATAL.
- core_req_i  in  [NHARTS-1:0]  per-hart request.
- core_we_i  in  [NHARTS-1:0]  per-hart write enable.
- core_addr_i  in  [NHARTS-1:0][AW-1:0]  per-hart address.
- core_wdata_i  in  [NHARTS-1:0][DW-1:0]  per-hart write data.
- voted_req_o  out  1  bitwise 2-of-3 majority of req.
- voted_we_o  out  1  majority of we.
- voted_addr_o  out  AW  majority of addr.
- voted_wdata_o  out  DW  majority of wdata.
- tmr_error_o  out  1  single-hart fault latched.
- voter_id_error_o  out  [NHARTS-1:0]  one-hot mask of the faulty hart.
- fatal_error_o  out  1  uncorrectable disagreement latched.
- error_count_o  out  CNT_W  number of FAULT/FATAL entries.

Behaviour:
- Voted outputs: purely combinational bitwise majority, zero latency, valid regardless of state or enable_i.
- Signature per hart: {req, we, addr, wdata}. When req=0, we/addr/wdata are masked to 0 before comparison.
- Pairwise mismatch flags: m01, m02, m12.
- Classification:
  - CLS_OK: no flag set.
  - CLS_SINGLE: exactly two flags set. Faulty id is the hart common to both (m01&m02 gives 0, m01&m12 gives 1, m02&m12 gives 2).
  - CLS_TRIPLE: all three flags set. One flag alone cannot occur.
- Registered FSM states: MON_IDLE, MON_WATCH, MON_PENDING, MON_FAULT, MON_FATAL. Also registered: candidate id cand[1:0] and persistence counter pcnt[3:0].
- Priority, highest first: rst_ni, then clear_i, then enable_i low, then classification.
- clear_i in any state: next state MON_IDLE; pcnt and cand are cleared.
- enable_i=0 in MON_WATCH or MON_PENDING: next state MON_IDLE; candidate discarded, no report. enable_i does not release MON_FAULT or MON_FATAL.
- MON_IDLE: enable_i=1 goes to MON_WATCH. Nothing is classified in MON_IDLE.
- MON_WATCH:
  - CLS_SINGLE: cand=id, pcnt=1. If PERSIST=1 go directly to MON_FAULT, otherwise MON_PENDING.
  - CLS_TRIPLE: go to MON_FATAL.
  - CLS_OK: stay.
- MON_PENDING:
  - CLS_SINGLE with the same id: pcnt+1. When pcnt+1 reaches PERSIST, go to MON_FAULT.
  - CLS_OK: return to MON_WATCH (transient, nothing reported).
  - CLS_SINGLE with a different id, or CLS_TRIPLE: go to MON_FATAL.
- MON_FAULT:
  - Outputs: tmr_error_o=1, voter_id_error_o=1<<cand.
  - Held until clear_i. Further mismatches are ignored.
- MON_FATAL:
  - Outputs: fatal_error_o=1, tmr_error_o=0, voter_id_error_o=0.
  - Held until clear_i.
- Latency: flags assert in the cycle after the PERSIST-th consecutive mismatching cycle, and deassert the cycle after clear_i.
- error_count_o:
  - Increments by one on each transition into MON_FAULT or MON_FATAL.
  - Saturates at all-ones.
  - Not affected by clear_i; cleared only by reset.
- Reset values: state MON_IDLE, cand 0, pcnt 0, tmr_error_o 0, voter_id_error_o 0, fatal_error_o 0, error_count_o 0.
- Reset asserted mid-PENDING or in FAULT clears everything immediately (asynchronous assertion).
- All status outputs are driven from registers; none are combinational from the inputs.

Decomposition:
- Shared package tmr_mon_pkg contains:
  - enum tmr_mon_state_e (the five states);
  - enum tmr_mon_class_e (CLS_OK, CLS_SINGLE, CLS_TRIPLE);
  - localparam NHARTS_TMR = 3.
- One combinational sub-module, tmr_vote_classifier:
  - inputs: the three masked signatures;
  - outputs: majority signature, class, faulty id.
- tmr_error_monitor holds the FSM, counters and output registers.

Test Plan:
- Normal lockstep: enable_i=1; all harts req=1, addr=0x1000_0040, wdata=0xDEAD_BEEF for 100 cycles. Expect voted_addr_o=0x1000_0040, voted_wdata_o=0xDEADBEEF, tmr_error_o=0, error_count_o=0.
- Transient, PERSIST=2: hart1 wdata=0xDEADBEEE for 1 cycle only. Expect voted_wdata_o=0xDEADBEEF throughout, state returns to WATCH, no flags, error_count_o=0.
- Persistent fault: hart2 addr=0x2000_0000 for cycles t and t+1 (others 0x1000_0040). Expect tmr_error_o=1 and voter_id_error_o=3'b100 from cycle t+2, voted_addr_o=0x1000_0040, error_count_o=1.
- Triple disagreement: wdata 0x1/0x2/0x4 on harts 0/1/2 in WATCH. Expect fatal_error_o=1 next cycle, tmr_error_o=0, voter_id_error_o=0, error_count_o=1.
- Clear and masking:
  - clear_i pulse while in FAULT: all flags return to 0 next cycle, and MON_WATCH is re-entered one cycle later if enable_i=1.
  - Separately: all req=0 with differing addr/wdata on hart0 gives no error.
- Abort paths:
  - PENDING then enable_i=0: goes to IDLE, no flag.
  - PENDING with the faulty id switching to hart0: goes to FATAL.
  - rst_ni low mid-PENDING: all outputs 0 immediately.
